// File: rtl/ah_arb_pkg.sv
// Shared arbiter helpers: legality limits, pointer increment, one-hot decode.
// Latency: none (pure functions and types); backpressure: not applicable.
package ah_arb_pkg;

    localparam int ARB_MAX_N = 64;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_PICK = 2'd2
    } arb_op_e;

    function automatic bit arb_n_legal(input int n);
        return (n >= 1) && (n <= ARB_MAX_N);
    endfunction

    // Wrap-safe increment: never yields a value >= n, even for non-power-of-2 n.
    function automatic int rr_next_ptr(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

    function automatic logic [5:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) idx = idx | 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ah_rr_pick.sv
// Combinational rotated-priority picker: first set req at or after ptr, wrapping.
// Latency: combinational; backpressure: none (pure function of req and ptr).
module ah_rr_pick
    import ah_arb_pkg::*;
#(
    parameter int N   = 24,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           win_vld,
    output logic [IDW-1:0] win_id,
    output logic [N-1:0]   win_onehot
);

    logic [N-1:0] rot;
    logic [IDW:0] off;
    logic [IDW:0] sum;

    always_comb begin
        // Doubling the vector turns the wrapped search into a plain shift.
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = (IDW+1)'(i);
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
        win_vld    = |req;
        win_id     = sum[IDW-1:0];
        win_onehot = win_vld ? (N'(1) << sum[IDW-1:0]) : '0;
    end

endmodule

// File: rtl/ah_rr_arbiter_lock.sv
// Round-robin arbiter with per-requester grant lock and arbitration enable.
// Latency: req to registered grant in one cycle; backpressure: en low blocks new grants only.
module ah_rr_arbiter_lock
    import ah_arb_pkg::*;
#(
    parameter int N   = 24,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    localparam bit N_OK = arb_n_legal(N);

    if (!N_OK) begin : g_bad_n
        $error("ah_rr_arbiter_lock: N must be in 1..64");
    end

    logic [N-1:0]   grant_q;
    logic           grant_vld_q;
    logic [IDW-1:0] grant_id_q;
    logic [IDW-1:0] ptr_q;

    logic           win_vld;
    logic [IDW-1:0] win_id;
    logic [N-1:0]   win_onehot;
    arb_op_e        op;

    ah_rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .win_vld    (win_vld),
        .win_id     (win_id),
        .win_onehot (win_onehot)
    );

    // grant_q is at most one-hot, so any overlap identifies the holder's own req & lock.
    always_comb begin
        op = ARB_IDLE;
        if (|(grant_q & req & lock)) op = ARB_HOLD;
        else if (en && win_vld)      op = ARB_PICK;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
            grant_id_q  <= '0;
            ptr_q       <= '0;
        end else begin
            case (op)
                ARB_HOLD: ;
                ARB_PICK: begin
                    grant_q     <= win_onehot;
                    grant_vld_q <= 1'b1;
                    grant_id_q  <= win_id;
                    ptr_q       <= IDW'(rr_next_ptr(int'(win_id), N));
                end
                default: begin
                    grant_q     <= '0;
                    grant_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_vld_q;
    assign grant_id    = grant_id_q;

endmodule
